// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, RV32I decode constants and issue-stage types
// ALU_FLAG_BRANCH_EN adds the branch tag carried alongside each issued item.
package alu_pkg;

  localparam logic [3:0] ALU_OP_PASS_B   = 4'd0;
  localparam logic [3:0] ALU_OP_B_PLUS4  = 4'd1;
  localparam logic [3:0] ALU_OP_ADD      = 4'd2;
  localparam logic [3:0] ALU_OP_SUB      = 4'd3;
  localparam logic [3:0] ALU_OP_ADD_CLR0 = 4'd4;
  localparam logic [3:0] ALU_OP_SLL      = 4'd5;
  localparam logic [3:0] ALU_OP_SRL      = 4'd6;
  localparam logic [3:0] ALU_OP_SRA      = 4'd7;
  localparam logic [3:0] ALU_OP_SLT      = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU     = 4'd9;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_SR   = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        illegal;
  } issue_item_t;

  typedef struct packed {
    issue_item_t item;
`ifdef ALU_FLAG_BRANCH_EN
    logic        is_branch;
    logic [2:0]  br_f3;
`endif
  } stage_t;

  function automatic logic branch_taken(input logic [2:0] f3, input logic z, n, c, v);
    case (f3)
      F3_BEQ:  return z;
      F3_BNE:  return ~z;
      F3_BLT:  return n ^ v;
      F3_BGE:  return ~(n ^ v);
      F3_BLTU: return c;
      F3_BGEU: return ~c;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - input/output handshake bundle of the ALU issue stage
// ALU_FLAG_BRANCH_EN adds the flag inputs and branch result outputs.
interface alu_issue_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        illegal;
`ifdef ALU_FLAG_BRANCH_EN
  logic        alu_z;
  logic        alu_n;
  logic        alu_c;
  logic        alu_v;
  logic        br_valid;
  logic        br_taken;

  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready, alu_z, alu_n, alu_c, alu_v,
    output in_ready, out_valid, alu_op, alu_a, alu_b, illegal, br_valid, br_taken
  );
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready, alu_z, alu_n, alu_c, alu_v,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, illegal, br_valid, br_taken
  );
`else
  modport slave (
    input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    output in_ready, out_valid, alu_op, alu_a, alu_b, illegal
  );
  modport master (
    output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
    input  in_ready, out_valid, alu_op, alu_a, alu_b, illegal
  );
`endif

endinterface

// File: rtl/alu_issue_decode.sv
// rtl/alu_issue_decode.sv - combinational RV32I decode into ALU op and operands
// Illegal encodings collapse to ILLEGAL_OP with zeroed operands and no branch tag.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  output issue_item_t item_o,
  output logic        is_branch_o,
  output logic [2:0]  br_f3_o
);

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_u;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        legal;
  logic        is_branch;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign imm_i = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_u = {instr_i[31:12], 12'h000};

  always_comb begin
    op        = ILLEGAL_OP;
    a         = '0;
    b         = '0;
    legal     = 1'b0;
    is_branch = 1'b0;
    case (opc)
      OPC_LUI:   begin op = ALU_OP_PASS_B;  b = imm_u; legal = 1'b1; end
      OPC_AUIPC: begin op = ALU_OP_ADD;     a = pc_i; b = imm_u; legal = 1'b1; end
      OPC_JAL:   begin op = ALU_OP_B_PLUS4; b = pc_i; legal = 1'b1; end
      OPC_JALR: begin
        op = ALU_OP_ADD_CLR0; a = rs1_i; b = imm_i;
        legal = (f3 == 3'b000);
      end
      OPC_LOAD:  begin op = ALU_OP_ADD; a = rs1_i; b = imm_i; legal = 1'b1; end
      OPC_STORE: begin op = ALU_OP_ADD; a = rs1_i; b = imm_s; legal = 1'b1; end
      OPC_BRANCH: begin
        a = rs1_i; b = rs2_i; legal = 1'b1; is_branch = 1'b1;
        case (f3)
          F3_BEQ, F3_BNE:   op = ALU_OP_SUB;
          F3_BLT, F3_BGE:   op = ALU_OP_SLT;
          F3_BLTU, F3_BGEU: op = ALU_OP_SLTU;
          default:          legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        a = rs1_i; b = imm_i;
        // Shift immediates keep funct7 in imm_i[11:5]; the ALU only looks at B[4:0].
        case (f3)
          F3_ADD:  begin op = ALU_OP_ADD;  legal = 1'b1; end
          F3_SLT:  begin op = ALU_OP_SLT;  legal = 1'b1; end
          F3_SLTU: begin op = ALU_OP_SLTU; legal = 1'b1; end
          F3_SLL:  begin op = ALU_OP_SLL;  legal = (f7 == F7_BASE); end
          F3_SR: begin
            op    = (f7 == F7_ALT) ? ALU_OP_SRA : ALU_OP_SRL;
            legal = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          default: legal = 1'b0;
        endcase
      end
      OPC_OP: begin
        a = rs1_i; b = rs2_i; legal = 1'b1;
        case ({f7, f3})
          {F7_BASE, F3_ADD}:  op = ALU_OP_ADD;
          {F7_ALT,  F3_ADD}:  op = ALU_OP_SUB;
          {F7_BASE, F3_SLL}:  op = ALU_OP_SLL;
          {F7_BASE, F3_SLT}:  op = ALU_OP_SLT;
          {F7_BASE, F3_SLTU}: op = ALU_OP_SLTU;
          {F7_BASE, F3_SR}:   op = ALU_OP_SRL;
          {F7_ALT,  F3_SR}:   op = ALU_OP_SRA;
          default:            legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      op        = ILLEGAL_OP;
      a         = '0;
      b         = '0;
      is_branch = 1'b0;
    end
  end

  assign item_o      = '{op: op, a: a, b: b, illegal: ~legal};
  assign is_branch_o = is_branch;
  assign br_f3_o     = f3;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - registered ALU issue stage with one-entry skid buffer
// ALU_FLAG_BRANCH_EN resolves branches from the ALU flags one cycle after issue.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int         XLEN         = 32,
  parameter logic [3:0] ILLEGAL_OP   = 4'b0000,
  parameter bit         DROP_ILLEGAL = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus
);

  issue_item_t dec_item;
  logic        dec_is_branch;
  logic [2:0]  dec_br_f3;
  stage_t      dec_s;
  stage_t      out_q, out_d;
  stage_t      skid_q, skid_d;
  logic        out_valid_q, out_valid_d;
  logic        skid_valid_q, skid_valid_d;
  logic        in_fire;
  logic        push;
  logic        out_free;

  alu_issue_decode #(.ILLEGAL_OP(ILLEGAL_OP)) u_decode (
    .instr_i     (bus.instr),
    .pc_i        (bus.pc),
    .rs1_i       (bus.rs1_data),
    .rs2_i       (bus.rs2_data),
    .item_o      (dec_item),
    .is_branch_o (dec_is_branch),
    .br_f3_o     (dec_br_f3)
  );

`ifdef ALU_FLAG_BRANCH_EN
  assign dec_s = '{item: dec_item, is_branch: dec_is_branch, br_f3: dec_br_f3};
`else
  logic [3:0] unused_br;
  assign unused_br = {dec_is_branch, dec_br_f3};
  assign dec_s     = '{item: dec_item};
`endif

  // in_ready depends only on the skid flop, so out_ready never reaches it combinationally.
  assign in_fire  = bus.in_valid & ~skid_valid_q;
  assign push     = in_fire & ~(DROP_ILLEGAL & dec_item.illegal);
  assign out_free = ~out_valid_q | bus.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) out_d = dec_s;
      end
    end else if (push) begin
      skid_d       = dec_s;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign bus.in_ready  = ~skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.alu_op    = out_q.item.op;
  assign bus.alu_a     = out_q.item.a[XLEN-1:0];
  assign bus.alu_b     = out_q.item.b[XLEN-1:0];
  assign bus.illegal   = out_q.item.illegal;

`ifdef ALU_FLAG_BRANCH_EN
  logic br_valid_q;
  logic br_taken_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_valid_q <= 1'b0;
      br_taken_q <= 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      br_valid_q <= out_q.is_branch;
      if (out_q.is_branch)
        br_taken_q <= branch_taken(out_q.br_f3, bus.alu_z, bus.alu_n, bus.alu_c, bus.alu_v);
    end else begin
      br_valid_q <= 1'b0;
    end
  end

  assign bus.br_valid = br_valid_q;
  assign bus.br_taken = br_taken_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
// ALU_FLAG_BRANCH_EN enables the branch-resolution sequence.
module tb_alu_issue_stage;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } exp_t;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ill;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;
  int   n_out   = 0;
  bit   mon_en  = 1'b0;
  exp_t sb[$];

  alu_issue_stage_if bus ();

  alu_issue_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.op = op; e.a = a; e.b = b; e.ill = 1'b0;
    return e;
  endfunction

  // Reference decode written from the instruction-set tables, mnemonic by mnemonic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc,
                                      input logic [31:0] r1, input logic [31:0] r2);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_u;
    f3    = ins[14:12];
    f7    = ins[31:25];
    imm_i = 32'($signed(ins[31:20]));
    imm_s = 32'($signed({ins[31:25], ins[11:7]}));
    imm_u = ins & 32'hFFFF_F000;
    e.op = 4'd0; e.a = 32'd0; e.b = 32'd0; e.ill = 1'b1;
    case (ins[6:0])
      7'h37: e = mk(4'd0, 32'd0, imm_u);
      7'h17: e = mk(4'd2, pc, imm_u);
      7'h6F: e = mk(4'd1, 32'd0, pc);
      7'h67: if (f3 == 3'd0) e = mk(4'd4, r1, imm_i);
      7'h03: e = mk(4'd2, r1, imm_i);
      7'h23: e = mk(4'd2, r1, imm_s);
      7'h63: begin
        if (f3 == 3'd0 || f3 == 3'd1) e = mk(4'd3, r1, r2);
        if (f3 == 3'd4 || f3 == 3'd5) e = mk(4'd8, r1, r2);
        if (f3 == 3'd6 || f3 == 3'd7) e = mk(4'd9, r1, r2);
      end
      7'h13: begin
        if (f3 == 3'd0) e = mk(4'd2, r1, imm_i);
        if (f3 == 3'd2) e = mk(4'd8, r1, imm_i);
        if (f3 == 3'd3) e = mk(4'd9, r1, imm_i);
        if (f3 == 3'd1 && f7 == 7'h00) e = mk(4'd5, r1, imm_i);
        if (f3 == 3'd5 && f7 == 7'h00) e = mk(4'd6, r1, imm_i);
        if (f3 == 3'd5 && f7 == 7'h20) e = mk(4'd7, r1, imm_i);
      end
      7'h33: begin
        if (f7 == 7'h00 && f3 == 3'd0) e = mk(4'd2, r1, r2);
        if (f7 == 7'h20 && f3 == 3'd0) e = mk(4'd3, r1, r2);
        if (f7 == 7'h00 && f3 == 3'd1) e = mk(4'd5, r1, r2);
        if (f7 == 7'h00 && f3 == 3'd2) e = mk(4'd8, r1, r2);
        if (f7 == 7'h00 && f3 == 3'd3) e = mk(4'd9, r1, r2);
        if (f7 == 7'h00 && f3 == 3'd5) e = mk(4'd6, r1, r2);
        if (f7 == 7'h20 && f3 == 3'd5) e = mk(4'd7, r1, r2);
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 10))
      0: r[6:0] = 7'h37;
      1: r[6:0] = 7'h17;
      2: r[6:0] = 7'h6F;
      3: r[6:0] = 7'h67;
      4: r[6:0] = 7'h03;
      5: r[6:0] = 7'h23;
      6: r[6:0] = 7'h63;
      7: r[6:0] = 7'h13;
      8: r[6:0] = 7'h33;
      default: ;
    endcase
    if ($urandom_range(0, 2) != 0) r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
    return r;
  endfunction

  // Occupancy scoreboard: the stage holds sb.size() items, output valid iff any, ready iff < 2.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      exp_t e;
      chk("out_valid_vs_occupancy", 80'(bus.out_valid), 80'(sb.size() > 0));
      chk("in_ready_vs_occupancy", 80'(bus.in_ready), 80'(sb.size() < 2));
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_issue", 80'd1, 80'd0);
        end else begin
          e = sb.pop_front();
          n_out++;
          chk("issued_item", {bus.alu_op, bus.alu_a, bus.alu_b, bus.illegal},
              {e.op, e.a, e.b, e.ill});
        end
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(ref_decode(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    int   n0;
    bit   acc;

    vt.push_back('{"addi",     32'h00A00093, 32'h0,   32'h5,        32'h0, 4'd2, 32'h5,        32'hA,        1'b0});
    vt.push_back('{"srai",     32'h4020D093, 32'h0,   32'h80000000, 32'h0, 4'd7, 32'h80000000, 32'h402,      1'b0});
    vt.push_back('{"slli_bad", 32'h40209093, 32'h0,   32'h1,        32'h0, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"jal",      32'h0080006F, 32'h100, 32'h7,        32'h9, 4'd1, 32'h0,        32'h100,      1'b0});
    vt.push_back('{"xor",      32'h0020C0B3, 32'h0,   32'h3,        32'h4, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"lui",      32'h123450B7, 32'h0,   32'h3,        32'h4, 4'd0, 32'h0,        32'h12345000, 1'b0});
    vt.push_back('{"auipc",    32'hFFFFF097, 32'h200, 32'h3,        32'h4, 4'd2, 32'h200,      32'hFFFFF000, 1'b0});
    vt.push_back('{"jalr",     32'hFFC100E7, 32'h0,   32'h1001,     32'h4, 4'd4, 32'h1001,     32'hFFFFFFFC, 1'b0});
    vt.push_back('{"jalr_f3",  32'hFFC110E7, 32'h0,   32'h1001,     32'h4, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"lw",       32'h00812083, 32'h0,   32'h1000,     32'h4, 4'd2, 32'h1000,     32'h8,        1'b0});
    vt.push_back('{"sw",       32'hFE312C23, 32'h0,   32'h2000,     32'h4, 4'd2, 32'h2000,     32'hFFFFFFF8, 1'b0});
    vt.push_back('{"beq",      32'h00208063, 32'h0,   32'h7,        32'h7, 4'd3, 32'h7,        32'h7,        1'b0});
    vt.push_back('{"bltu",     32'h0020E063, 32'h0,   32'h1,        32'h2, 4'd9, 32'h1,        32'h2,        1'b0});
    vt.push_back('{"br_f3_010",32'h0020A063, 32'h0,   32'h1,        32'h2, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"sub",      32'h402080B3, 32'h0,   32'h9,        32'h2, 4'd3, 32'h9,        32'h2,        1'b0});
    vt.push_back('{"sra",      32'h4020D0B3, 32'h0,   32'h9,        32'h2, 4'd7, 32'h9,        32'h2,        1'b0});
    vt.push_back('{"or",       32'h0020E0B3, 32'h0,   32'h9,        32'h2, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"mul_f7",   32'h022080B3, 32'h0,   32'h9,        32'h2, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"bad_opc",  32'h0000007F, 32'h0,   32'h9,        32'h2, 4'd0, 32'h0,        32'h0,        1'b1});
    vt.push_back('{"sltiu",    32'hFFF0B093, 32'h0,   32'h9,        32'h2, 4'd9, 32'h9,        32'hFFFFFFFF, 1'b0});

    rst_n         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.instr     = 32'h0;
    bus.pc        = 32'h0;
    bus.rs1_data  = 32'h0;
    bus.rs2_data  = 32'h0;
`ifdef ALU_FLAG_BRANCH_EN
    bus.alu_z = 1'b0; bus.alu_n = 1'b0; bus.alu_c = 1'b0; bus.alu_v = 1'b0;
`endif
    #2 rst_n = 1'b0;
    #1;
    chk("reset_out_valid", 80'(bus.out_valid), 80'd0);
    chk("reset_in_ready", 80'(bus.in_ready), 80'd1);
    chk("reset_data", {bus.alu_op, bus.alu_a, bus.alu_b, bus.illegal}, 80'd0);
`ifdef ALU_FLAG_BRANCH_EN
    chk("reset_br", {bus.br_valid, bus.br_taken}, 80'd0);
`endif
    tick();
    tick();
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Decode table, one item at a time with the output always ready.
    bus.out_ready = 1'b1;
    foreach (vt[i]) begin
      bus.in_valid = 1'b1;
      bus.instr    = vt[i].instr;
      bus.pc       = vt[i].pc;
      bus.rs1_data = vt[i].rs1;
      bus.rs2_data = vt[i].rs2;
      tick();
      bus.in_valid = 1'b0;
      chk({"vec_", vt[i].name}, {bus.out_valid, bus.alu_op, bus.alu_a, bus.alu_b, bus.illegal},
          {1'b1, vt[i].op, vt[i].a, vt[i].b, vt[i].ill});
    end
    tick();

    // Stall with three offered items: skid fills, ready drops, order preserved.
    n0 = n_out;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr = 32'h00100093; bus.rs1_data = 32'h11;
    tick();
    chk("stall_ready_after_1st", 80'(bus.in_ready), 80'd1);
    bus.instr = 32'h00200093; bus.rs1_data = 32'h22;
    tick();
    chk("stall_ready_after_2nd", 80'(bus.in_ready), 80'd0);
    bus.instr = 32'h00300093; bus.rs1_data = 32'h33;
    tick();
    chk("stall_hold_op", {bus.out_valid, bus.alu_a, bus.alu_b}, {1'b1, 32'h11, 32'h1});
    tick();
    bus.out_ready = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      acc = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    chk("stall_3rd_accepted", 80'(acc), 80'd1);
    repeat (4) tick();
    chk("stall_items_out", 80'(n_out - n0), 80'd3);

    // Reset with output valid and skid full.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr = 32'h00100093; bus.rs1_data = 32'h1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    chk("pre_reset_full", {bus.out_valid, bus.in_ready}, 80'b10);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_reset_out_valid", 80'(bus.out_valid), 80'd0);
    chk("async_reset_in_ready", 80'(bus.in_ready), 80'd1);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.instr = 32'h00A00093; bus.rs1_data = 32'h5;
    tick();
    bus.in_valid = 1'b0;
    chk("post_reset_item", {bus.out_valid, bus.alu_op, bus.alu_a, bus.alu_b},
        {1'b1, 4'd2, 32'h5, 32'hA});
    tick();

`ifdef ALU_FLAG_BRANCH_EN
    bus.alu_z = 1'b0; bus.alu_n = 1'b1; bus.alu_c = 1'b0; bus.alu_v = 1'b0;
    bus.in_valid = 1'b1;
    bus.instr = 32'h0020C063; bus.rs1_data = 32'hFFFFFFFF; bus.rs2_data = 32'h1;
    tick();
    bus.in_valid = 1'b0;
    chk("blt_no_early_br", 80'(bus.br_valid), 80'd0);
    tick();
    chk("blt_br", {bus.br_valid, bus.br_taken}, 80'b11);
    tick();
    chk("blt_br_pulse", 80'(bus.br_valid), 80'd0);
    bus.alu_c = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = 32'h0020F063;
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("bgeu_br", {bus.br_valid, bus.br_taken}, 80'b10);
    tick();
`endif

    // Randomized traffic against the reference decode and occupancy model.
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.instr     = rand_instr();
      bus.pc        = $urandom;
      bus.rs1_data  = $urandom;
      bus.rs2_data  = $urandom;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick();
    chk("drain_empty", 80'(sb.size()), 80'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
